clkdiv_bank: RTL and testbench

- Parametrised, runtime-programmable bank of NUM_CH clock dividers; successor to the fixed /2, /10, /25 generators.
- Each channel produces a near-50%-duty divided clock and a single-cycle tick enable, both synchronous to clk_50.
- Divisors are reprogrammed through a valid/ready config port and change glitch-free at period boundaries.
- Feeds pixel/CPU/audio timing logic; downstream logic prefers tick_o as a clock enable over using clk_o as a clock.

---
 rtl/clkdiv_pkg.sv | 26 ++
 rtl/clkdiv_bank_if.sv | 27 ++
 rtl/clkdiv_channel.sv | 81 ++++++++
 rtl/clkdiv_bank.sv | 66 ++++++
 tb/tb_clkdiv_bank.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the clkdiv_bank divider bank.
// Helpers take 32-bit values so any counter width can use them through a cast.
package clkdiv_pkg;

  localparam int unsigned MIN_DIV = 2;

  // Per-channel decision taken at every clock edge.
  typedef enum logic [1:0] {
    EV_HOLD,
    EV_COUNT,
    EV_RESTART
  } ch_ev_e;

  function automatic int unsigned ch_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned clamp_div(input int unsigned d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

  function automatic int unsigned high_len(input int unsigned d);
    return (d + 1) >> 1;
  endfunction

endpackage

// File: rtl/clkdiv_bank_if.sv
// Valid/ready divisor-programming port of the clkdiv_bank.
// The master drives a write request; the slave answers with cfg_ready.
interface clkdiv_bank_if #(
  parameter int CH_W  = 2,
  parameter int CNT_W = 8
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_div,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_div,
    output cfg_ready
  );

endinterface

// File: rtl/clkdiv_channel.sv
// One divider channel: period counter, active/shadow divisor pair and
// registered clock/tick outputs computed from the next counter value.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int RESET_DIV = 2
) (
  input  logic             clk_50,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             pending,
  output logic             clk_o,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] shadow;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] div_nxt;
  logic             run;
  logic             apply;
  ch_ev_e           ev;

  // A channel that was idle last cycle restarts its period instead of counting on.
  always_comb begin
    ev      = EV_HOLD;
    apply   = 1'b0;
    cnt_nxt = '0;
    div_nxt = div;
    if (en) begin
      if (!run || sync || (cnt == div - CNT_W'(1))) begin
        ev = EV_RESTART;
      end else begin
        ev = EV_COUNT;
      end
    end
    // Idle channels take a pending divisor immediately; running ones only at a period boundary.
    apply = pending && (ev != EV_COUNT);
    if (ev == EV_COUNT) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
    if (apply) begin
      div_nxt = shadow;
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      div     <= CNT_W'(RESET_DIV);
      pending <= 1'b0;
      run     <= 1'b0;
      clk_o   <= 1'b0;
      tick_o  <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      div <= div_nxt;
      run <= en;
      // wr is only granted while pending is clear, so it never collides with apply.
      if (wr) begin
        pending <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
      clk_o  <= en && (32'(cnt_nxt) < high_len(32'(div_nxt)));
      tick_o <= en && (cnt_nxt == '0);
    end
  end

  always_ff @(posedge clk_50) begin
    if (wr) begin
      shadow <= wr_div;
    end
  end

endmodule

// File: rtl/clkdiv_bank.sv
// Bank of NUM_CH runtime-programmable clock dividers with a shared config port.
// Define CLKDIV_PHASE_ALIGN_EN to add sync_i, which restarts every running channel together.
module clkdiv_bank
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH    = 3,
  parameter int CNT_W     = 8,
  parameter int RESET_DIV = 2
) (
  input  logic              clk_50,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en_i,
`ifdef CLKDIV_PHASE_ALIGN_EN
  input  logic              sync_i,
`endif
  clkdiv_bank_if.slave      cfg,
  output logic [NUM_CH-1:0] clk_o,
  output logic [NUM_CH-1:0] tick_o
);

  localparam int CH_W  = ch_width(NUM_CH);
  localparam int SLOTS = 1 << CH_W;

  logic [SLOTS-1:0]  busy;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] wr;
  logic [CNT_W-1:0]  div_cap;
  logic              accept;
  logic              sync;

`ifdef CLKDIV_PHASE_ALIGN_EN
  assign sync = sync_i;
`else
  assign sync = 1'b0;
`endif

  // Unused channel slots read as never busy, so writes to them are taken and dropped.
  always_comb begin
    busy             = '0;
    busy[NUM_CH-1:0] = pending;
  end

  assign cfg.cfg_ready = !busy[cfg.cfg_ch];
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;
  assign div_cap       = CNT_W'(clamp_div(32'(cfg.cfg_div)));

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr[i] = accept && (cfg.cfg_ch == CH_W'(i));

    clkdiv_channel #(
      .CNT_W     (CNT_W),
      .RESET_DIV (RESET_DIV)
    ) u_channel (
      .clk_50  (clk_50),
      .rst_n   (rst_n),
      .en      (en_i[i]),
      .sync    (sync),
      .wr      (wr[i]),
      .wr_div  (div_cap),
      .pending (pending[i]),
      .clk_o   (clk_o[i]),
      .tick_o  (tick_o[i])
    );
  end

endmodule

// File: tb/tb_clkdiv_bank.sv
// Self-checking bench for clkdiv_bank: a cycle model feeds a scoreboard,
// plus table-driven config writes and hand-written period measurements.
module tb_clkdiv_bank;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;
  localparam int CH_W   = 2;

  typedef struct packed {
    logic [NUM_CH-1:0] c;
    logic [NUM_CH-1:0] t;
  } exp_t;

  typedef struct {
    logic [NUM_CH-1:0] en;
    logic              vld;
    logic [CH_W-1:0]   ch;
    logic [CNT_W-1:0]  div;
    logic              rdy;
    int                cyc;
  } row_t;

  logic              clk_50 = 1'b0;
  logic              rst_n  = 1'b0;
  logic [NUM_CH-1:0] en     = '0;
  logic              sync   = 1'b0;
  logic [NUM_CH-1:0] clk_o;
  logic [NUM_CH-1:0] tick_o;

  int n_checks = 0;
  int n_fail   = 0;

  clkdiv_bank_if #(.CH_W(CH_W), .CNT_W(CNT_W)) cfg ();

  clkdiv_bank #(
    .NUM_CH    (NUM_CH),
    .CNT_W     (CNT_W),
    .RESET_DIV (2)
  ) dut (
    .clk_50 (clk_50),
    .rst_n  (rst_n),
    .en_i   (en),
`ifdef CLKDIV_PHASE_ALIGN_EN
    .sync_i (sync),
`endif
    .cfg    (cfg),
    .clk_o  (clk_o),
    .tick_o (tick_o)
  );

  always #5 clk_50 = ~clk_50;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model of the bank, advanced on every rising edge.
  logic  m_run  [NUM_CH];
  logic  m_pend [NUM_CH];
  int    m_cnt  [NUM_CH];
  int    m_div  [NUM_CH];
  int    m_sh   [NUM_CH];
  logic  m_acc;
  int    m_wch;
  exp_t  m_e;
  exp_t  chk_e;
  exp_t  sb[$];

  function automatic logic m_ready(input logic [CH_W-1:0] ch);
    int idx = int'(ch);
    if (idx >= NUM_CH) return 1'b1;
    return !m_pend[idx];
  endfunction

  always @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_run[i] = 1'b0; m_pend[i] = 1'b0; m_cnt[i] = 0; m_div[i] = 2; m_sh[i] = 2;
      end
      sb.delete();
    end else begin
      m_acc = cfg.cfg_valid && m_ready(cfg.cfg_ch);
      m_wch = int'(cfg.cfg_ch);
      m_e   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (!en[i]) begin
          if (m_pend[i]) begin m_div[i] = m_sh[i]; m_pend[i] = 1'b0; end
          m_cnt[i] = 0;
          m_run[i] = 1'b0;
        end else begin
          if (!m_run[i] || sync || m_cnt[i] == m_div[i] - 1) begin
            m_cnt[i] = 0;
            if (m_pend[i]) begin m_div[i] = m_sh[i]; m_pend[i] = 1'b0; end
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
          m_run[i]  = 1'b1;
          m_e.c[i]  = (m_cnt[i] < (m_div[i] + 1) / 2);
          m_e.t[i]  = (m_cnt[i] == 0);
        end
      end
      if (m_acc && m_wch < NUM_CH) begin
        m_sh[m_wch]   = (cfg.cfg_div < 2) ? 2 : int'(cfg.cfg_div);
        m_pend[m_wch] = 1'b1;
      end
      sb.push_back(m_e);
    end
  end

  always @(negedge clk_50) begin
    if (!rst_n) begin
      check("rst_clk_o", 32'(clk_o), 32'(0));
      check("rst_tick_o", 32'(tick_o), 32'(0));
    end else if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_empty: no expected entry for this cycle");
    end else begin
      chk_e = sb.pop_front();
      check("sb_clk_o", 32'(clk_o), 32'(chk_e.c));
      check("sb_tick_o", 32'(tick_o), 32'(chk_e.t));
      check("sb_cfg_ready", 32'(cfg.cfg_ready), 32'(m_ready(cfg.cfg_ch)));
    end
  end

  task automatic apply_row(input row_t r);
    @(negedge clk_50); #1;
    en            = r.en;
    cfg.cfg_valid = r.vld;
    cfg.cfg_ch    = r.ch;
    cfg.cfg_div   = r.div;
    #1 check("row_ready", 32'(cfg.cfg_ready), 32'(r.rdy));
    @(posedge clk_50);
    if (r.cyc > 1) begin
      @(negedge clk_50); #1;
      cfg.cfg_valid = 1'b0;
      repeat (r.cyc - 2) @(posedge clk_50);
      @(posedge clk_50);
    end
  endtask

  // Waits for a tick on channel ch, then counts ticks and high cycles over n cycles.
  task automatic measure(input string name, input int ch, input int n,
                         input int exp_ticks, input int exp_high);
    int  t = 0;
    int  h = 0;
    logic found = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk_50); #1;
      if (tick_o[ch]) begin found = 1'b1; break; end
    end
    check({name, "_found"}, 32'(found), 32'(1));
    if (found) begin
      for (int i = 0; i < n; i++) begin
        t += int'(tick_o[ch]);
        h += int'(clk_o[ch]);
        @(posedge clk_50); #1;
      end
      check({name, "_ticks"}, t, exp_ticks);
      check({name, "_high"}, h, exp_high);
    end
  endtask

  row_t tbl [9];

  initial begin
    int k;
    tbl[0] = '{3'b111, 1'b1, 2'd1, 8'd5,  1'b1, 1};
    tbl[1] = '{3'b111, 1'b1, 2'd1, 8'd25, 1'b0, 2};
    tbl[2] = '{3'b111, 1'b0, 2'd1, 8'd0,  1'b1, 10};
    tbl[3] = '{3'b111, 1'b1, 2'd1, 8'd25, 1'b1, 1};
    tbl[4] = '{3'b111, 1'b0, 2'd1, 8'd0,  1'b0, 1};
    tbl[5] = '{3'b111, 1'b1, 2'd0, 8'd0,  1'b1, 1};
    tbl[6] = '{3'b111, 1'b0, 2'd0, 8'd0,  1'b0, 1};
    tbl[7] = '{3'b111, 1'b1, 2'd3, 8'd9,  1'b1, 1};
    tbl[8] = '{3'b111, 1'b0, 2'd3, 8'd0,  1'b1, 3};

    cfg.cfg_valid = 1'b0;
    cfg.cfg_ch    = '0;
    cfg.cfg_div   = '0;
    repeat (3) @(posedge clk_50);
    #1 check("rst_ready", 32'(cfg.cfg_ready), 32'(1));

    // Release reset with all channels enabled at the default divide-by-2.
    @(negedge clk_50); #1;
    rst_n = 1'b1;
    en    = 3'b111;
    @(posedge clk_50); #1;
    check("en_first_tick", 32'(tick_o), 32'(3'b111));
    check("en_first_clk", 32'(clk_o), 32'(3'b111));
    @(posedge clk_50); #1;
    check("div2_low_tick", 32'(tick_o), 32'(0));
    check("div2_low_clk", 32'(clk_o), 32'(0));
    @(posedge clk_50); #1;
    check("div2_second_tick", 32'(tick_o), 32'(3'b111));

    for (int i = 0; i <= 2; i++) apply_row(tbl[i]);
    measure("ch1_div5", 1, 20, 4, 12);
    measure("ch0_div2", 0, 10, 5, 5);
    for (int i = 3; i <= 4; i++) apply_row(tbl[i]);
    measure("ch1_div25", 1, 50, 2, 26);
    for (int i = 5; i <= 8; i++) apply_row(tbl[i]);
    measure("ch0_clamp", 0, 10, 5, 5);
    measure("ch2_untouched", 2, 10, 5, 5);

    // Disable channel 2 while writing it; the divisor lands while idle.
    @(negedge clk_50); #1;
    en            = 3'b011;
    cfg.cfg_valid = 1'b1;
    cfg.cfg_ch    = 2'd2;
    cfg.cfg_div   = 8'd3;
    #1 check("dis_wr_ready", 32'(cfg.cfg_ready), 32'(1));
    @(posedge clk_50); #1;
    cfg.cfg_valid = 1'b0;
    check("dis_clk2", 32'(clk_o[2]), 32'(0));
    check("dis_tick2", 32'(tick_o[2]), 32'(0));
    check("dis_pending", 32'(cfg.cfg_ready), 32'(0));
    @(posedge clk_50); #1;
    check("dis_applied", 32'(cfg.cfg_ready), 32'(1));
    en = 3'b111;
    @(posedge clk_50); #1;
    check("reen_tick2", 32'(tick_o[2]), 32'(1));
    check("reen_clk2", 32'(clk_o[2]), 32'(1));
    measure("ch2_div3", 2, 9, 3, 6);

    // Async reset mid-period with a write pending.
    @(negedge clk_50); #1;
    cfg.cfg_valid = 1'b1;
    cfg.cfg_ch    = 2'd1;
    cfg.cfg_div   = 8'd7;
    #1 check("prerst_ready", 32'(cfg.cfg_ready), 32'(1));
    @(posedge clk_50); #2;
    rst_n         = 1'b0;
    cfg.cfg_valid = 1'b0;
    #1;
    check("arst_clk_o", 32'(clk_o), 32'(0));
    check("arst_tick_o", 32'(tick_o), 32'(0));
    check("arst_ready", 32'(cfg.cfg_ready), 32'(1));
    @(negedge clk_50); #1;
    rst_n = 1'b1;
    @(posedge clk_50); #1;
    check("postrst_tick", 32'(tick_o), 32'(3'b111));
    check("postrst_clk", 32'(clk_o), 32'(3'b111));
    measure("ch1_lost_write", 1, 10, 5, 5);

`ifdef CLKDIV_PHASE_ALIGN_EN
    apply_row('{3'b111, 1'b1, 2'd0, 8'd3, 1'b1, 1});
    apply_row('{3'b111, 1'b1, 2'd1, 8'd4, 1'b1, 1});
    apply_row('{3'b111, 1'b1, 2'd2, 8'd5, 1'b1, 1});
    apply_row('{3'b111, 1'b0, 2'd0, 8'd0, 1'b1, 13});
    @(negedge clk_50); #1;
    sync = 1'b1;
    @(posedge clk_50); #1;
    sync = 1'b0;
    check("sync_tick", 32'(tick_o), 32'(3'b111));
    check("sync_clk", 32'(clk_o), 32'(3'b111));
    k = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk_50); #1;
      if (tick_o == 3'b111) begin k = i; break; end
    end
    check("sync_recur", k, 60);
`endif

    repeat (3) @(posedge clk_50);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
